// File: rtl/ring_pe_nic_if.sv
// Processor register bus and router PE-port channels of the ring NIC.
// slave is the NIC's view; master is the processor/router side.
interface ring_pe_nic_if #(
    parameter int DATA_W = 64
);
    logic [1:0]        addr;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;
    logic              nic_en;
    logic              nic_wr_en;
    logic              net_polarity;
    logic              net_so;
    logic              net_ro;
    logic [DATA_W-1:0] net_do;
    logic              net_si;
    logic              net_ri;
    logic [DATA_W-1:0] net_di;

    modport slave (
        input  addr, d_in, nic_en, nic_wr_en, net_polarity, net_ro, net_si, net_di,
        output d_out, net_so, net_do, net_ri
    );

    modport master (
        output addr, d_in, nic_en, nic_wr_en, net_polarity, net_ro, net_si, net_di,
        input  d_out, net_so, net_do, net_ri
    );
endinterface

// File: rtl/ring_pe_nic.sv
// Ring router NIC: one-entry inject and eject buffers behind a 4-word register map.
// Injection is held until the router polarity matches the packet's VC bit.
module ring_pe_nic #(
    parameter int DATA_W = 64
) (
    input  logic         clk,
    input  logic         reset,
    ring_pe_nic_if.slave nic
);

    typedef enum logic [1:0] {
        REG_IN_DATA  = 2'b00,
        REG_IN_STAT  = 2'b01,
        REG_OUT_DATA = 2'b10,
        REG_OUT_STAT = 2'b11
    } reg_sel_e;

    logic [DATA_W-1:0] r_out_buf;
    logic              r_out_full;
    logic [DATA_W-1:0] r_in_buf;
    logic              r_in_full;
    logic [DATA_W-1:0] r_d_out;

    reg_sel_e w_sel;
    logic     w_wr;
    logic     w_rd;
    logic     w_send;
    logic     w_accept;
    logic     w_drain;

    assign w_sel    = reg_sel_e'(nic.addr);
    assign w_wr     = nic.nic_en & nic.nic_wr_en & (w_sel == REG_OUT_DATA);
    assign w_rd     = nic.nic_en & ~nic.nic_wr_en;
    assign w_send   = r_out_full & nic.net_ro & (nic.net_polarity == r_out_buf[DATA_W-1]);
    assign w_accept = nic.net_si & ~r_in_full;
    assign w_drain  = w_rd & (w_sel == REG_IN_DATA) & r_in_full;

    assign nic.net_so = w_send;
    assign nic.net_do = r_out_buf;
    assign nic.net_ri = ~r_in_full;
    assign nic.d_out  = r_d_out;

    // Send needs a full buffer and a write needs an empty one, so they never collide;
    // the same holds for arrival versus the draining read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_buf  <= '0;
            r_out_full <= 1'b0;
            r_in_buf   <= '0;
            r_in_full  <= 1'b0;
            r_d_out    <= '0;
        end else begin
            if (w_send) begin
                r_out_full <= 1'b0;
            end else if (w_wr && !r_out_full) begin
                r_out_buf  <= nic.d_in;
                r_out_full <= 1'b1;
            end

            if (w_accept) begin
                r_in_buf  <= nic.net_di;
                r_in_full <= 1'b1;
            end else if (w_drain) begin
                r_in_full <= 1'b0;
            end

            if (w_rd) begin
                case (w_sel)
                    REG_IN_DATA:  r_d_out <= r_in_buf;
                    REG_IN_STAT:  r_d_out <= {{(DATA_W-1){1'b0}}, r_in_full};
                    REG_OUT_DATA: r_d_out <= '0;
                    REG_OUT_STAT: r_d_out <= {{(DATA_W-1){1'b0}}, r_out_full};
                    default:      r_d_out <= '0;
                endcase
            end
        end
    end

endmodule
